// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels and ALU port bundle shared by alu_arbiter and its requesters
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int NUM_REQ = 4
);
   localparam int SHW = $clog2(WIDTH);
   logic [NUM_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NUM_REQ*WIDTH-1:0] req_operand_a, req_operand_b;
   logic [NUM_REQ*5-1:0]     req_alu_control;
   logic [NUM_REQ*SHW-1:0]   req_shift_amount;
   logic [WIDTH-1:0]         alu_operand_a, alu_operand_b, alu_result, rsp_result;
   logic [4:0]               alu_control;
   logic [SHW-1:0]           alu_shift_amount;
   logic                     alu_zero, alu_overflow, rsp_zero, rsp_overflow, busy;
   modport master (
      output req_valid, req_operand_a, req_operand_b, req_alu_control, req_shift_amount, rsp_ready,
             alu_result, alu_zero, alu_overflow,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, busy,
             alu_operand_a, alu_operand_b, alu_control, alu_shift_amount
   );
   modport slave (
      input  req_valid, req_operand_a, req_operand_b, req_alu_control, req_shift_amount, rsp_ready,
             alu_result, alu_zero, alu_overflow,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow, busy,
             alu_operand_a, alu_operand_b, alu_control, alu_shift_amount
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters; ALU_ARB_PERF_EN adds perf_ops/perf_wait
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int NUM_REQ = 4
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [31:0]  perf_ops,
   output logic [31:0]  perf_wait
`endif
);
   localparam int SHW = $clog2(WIDTH);
   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [IDW:0] NR = NUM_REQ[IDW:0];
   localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nxt;
   logic [IDW-1:0] rr_ptr, owner, grant;
   logic [IDW:0] cand;
   logic found, take, done;
   // Search starts at rr_ptr and wraps, so the last winner has lowest priority
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + k[IDW:0];
         cand = (cand >= NR) ? cand - NR : cand;
         if (!found && bus.req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            grant = cand[IDW-1:0];
         end
      end
   end
   assign take = (state == IDLE) && found;
   assign done = (state == RESP) && bus.rsp_ready[owner];
   assign bus.req_ready = (take && !rst) ? NUM_REQ'(1) << grant : '0;
   assign bus.rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
   assign bus.busy = state != IDLE;
   always_comb state_nxt = (state == IDLE) ? (found ? EXEC : IDLE) : (state == EXEC) ? RESP : (done ? IDLE : RESP);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         owner <= '0;
         bus.alu_operand_a <= '0;
         bus.alu_operand_b <= '0;
         bus.alu_control <= '0;
         bus.alu_shift_amount <= '0;
         bus.rsp_result <= '0;
         bus.rsp_zero <= 1'b0;
         bus.rsp_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take) begin
            owner <= grant;
            rr_ptr <= (grant == LAST) ? '0 : grant + IDW'(1);
            bus.alu_operand_a <= bus.req_operand_a[int'(grant)*WIDTH +: WIDTH];
            bus.alu_operand_b <= bus.req_operand_b[int'(grant)*WIDTH +: WIDTH];
            bus.alu_control <= bus.req_alu_control[int'(grant)*5 +: 5];
            bus.alu_shift_amount <= bus.req_shift_amount[int'(grant)*SHW +: SHW];
         end
         if (state == EXEC) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero <= bus.alu_zero;
            bus.rsp_overflow <= bus.alu_overflow;
         end
      end
   end
`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops <= '0;
         perf_wait <= '0;
      end else begin
         if (done && ~&perf_ops) perf_ops <= perf_ops + 32'd1;
         if (|bus.req_valid && ~|bus.req_ready && ~&perf_wait) perf_wait <= perf_wait + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random stimulus against a cycle-level transaction model of alu_arbiter
module tb_alu_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   alu_arbiter_if #(.WIDTH(32), .NUM_REQ(N)) bus ();
`ifdef ALU_ARB_PERF_EN
   logic [31:0] perf_ops, perf_wait;
`endif
   alu_arbiter #(.WIDTH(32), .NUM_REQ(N)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ALU_ARB_PERF_EN
      ,
      .perf_ops(perf_ops),
      .perf_wait(perf_wait)
`endif
   );
   // Stand-in ALU: add/sub/slt/sll when bit4=0, and/or/xor/nor when bit4=1
   function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [4:0] c, input logic [4:0] sh);
      logic [31:0] r;
      logic v;
      v = 1'b0;
      if (c[4]) r = (c[1:0] == 2'd0) ? a & b : (c[1:0] == 2'd1) ? a | b : (c[1:0] == 2'd2) ? a ^ b : ~(a | b);
      else if (c[3:2] == 2'd0) begin
         r = a + b;
         v = c[0] && (a[31] == b[31]) && (r[31] != a[31]);
      end else if (c[3:2] == 2'd1) begin
         r = a - b;
         v = c[0] && (a[31] != b[31]) && (r[31] != a[31]);
      end else if (c[3:2] == 2'd2) r = c[0] ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
      else r = a << sh;
      return {v, r == 32'd0, r};
   endfunction
   assign {bus.alu_overflow, bus.alu_zero, bus.alu_result} = alu_f(bus.alu_operand_a, bus.alu_operand_b, bus.alu_control, bus.alu_shift_amount);
   logic [31:0] oa[N], ob[N];
   logic [4:0] oc[N], os[N];
   int n_chk = 0, n_fail = 0;
   int ptr = 0, own = 0, acc = 0, cyc = 0, m_ops = 0, m_wait = 0;
   bit pend = 1'b0;
   logic [31:0] la = '0, lb = '0, er = '0, hold;
   logic [4:0] lc = '0, ls = '0;
   logic ez = 1'b0, eo = 1'b0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   // One clock: drive at negedge, compare against the model, then advance the model across the edge
   task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] rr);
      int g;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      rst = r;
      bus.req_valid = v;
      bus.rsp_ready = rr;
      for (int i = 0; i < N; i++) begin
         bus.req_operand_a[i*32 +: 32] = oa[i];
         bus.req_operand_b[i*32 +: 32] = ob[i];
         bus.req_alu_control[i*5 +: 5] = oc[i];
         bus.req_shift_amount[i*5 +: 5] = os[i];
      end
      #1;
      g = -1;
      if (!r && !pend)
         for (int k = 0; k < N; k++)
            if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
      exp_rdy = (g >= 0) ? N'(1) << g : '0;
      check("req_ready", bus.req_ready, exp_rdy);
      if (!r) begin
         check("busy", bus.busy, pend);
         check("rsp_valid", bus.rsp_valid, (pend && cyc >= acc + 2) ? N'(1) << own : N'(0));
         if (pend && cyc >= acc + 2) begin
            check("rsp_result", bus.rsp_result, er);
            check("rsp_zero", bus.rsp_zero, ez);
            check("rsp_overflow", bus.rsp_overflow, eo);
         end
         check("alu_operand_a", bus.alu_operand_a, la);
         check("alu_operand_b", bus.alu_operand_b, lb);
         check("alu_control", bus.alu_control, lc);
         check("alu_shift_amount", bus.alu_shift_amount, ls);
`ifdef ALU_ARB_PERF_EN
         check("perf_ops", perf_ops, m_ops);
         check("perf_wait", perf_wait, m_wait);
`endif
      end
      if (r) begin
         pend = 1'b0;
         ptr = 0;
         own = 0;
         {la, lb, lc, ls} = '0;
         m_ops = 0;
         m_wait = 0;
      end else begin
         if (|v && g < 0) m_wait++;
         if (pend && cyc >= acc + 2 && rr[own]) begin
            pend = 1'b0;
            m_ops++;
         end else if (g >= 0) begin
            pend = 1'b1;
            own = g;
            acc = cyc;
            ptr = (g + 1) % N;
            {la, lb, lc, ls} = {oa[g], ob[g], oc[g], os[g]};
            {eo, ez, er} = alu_f(oa[g], ob[g], oc[g], os[g]);
         end
      end
      cyc++;
   endtask
   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         oa[i] = $urandom;
         ob[i] = ($urandom_range(3) == 0) ? oa[i] : $urandom;
         oc[i] = 5'($urandom);
         os[i] = 5'($urandom);
      end
   endtask
   initial begin
      for (int i = 0; i < N; i++) {oa[i], ob[i], oc[i], os[i]} = '0;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_operand_a = '0;
      bus.req_operand_b = '0;
      bus.req_alu_control = '0;
      bus.req_shift_amount = '0;
      step(1'b1, 4'hF, 4'h0);
      step(1'b1, 4'hF, 4'h0);
      check("rst_busy", bus.busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_alu_a", bus.alu_operand_a, 0);
      step(1'b0, 4'hF, 4'hF);
      check("first_grant", bus.req_ready, 4'b0001);
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      {oa[0], ob[0], oc[0], os[0]} = {32'd5, 32'd3, 5'b00000, 5'd0};
      step(1'b0, 4'b0001, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      check("single_alu_a", bus.alu_operand_a, 5);
      step(1'b0, 4'h0, 4'hF);
      check("single_rsp_valid", bus.rsp_valid, 4'b0001);
      check("single_result", bus.rsp_result, 8);
      check("single_zero", bus.rsp_zero, 0);
      check("single_ovf", bus.rsp_overflow, 0);
      {oa[2], ob[2], oc[2]} = {32'h7FFF_FFFF, 32'd1, 5'b00001};
      step(1'b0, 4'b0100, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      check("ovf_rsp_valid", bus.rsp_valid, 4'b0100);
      check("ovf_flag", bus.rsp_overflow, 1);
      {oa[2], ob[2], oc[2]} = {32'd7, 32'd7, 5'b00100};
      step(1'b0, 4'b0100, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      check("sub_result", bus.rsp_result, 0);
      check("sub_zero", bus.rsp_zero, 1);
      step(1'b1, 4'h0, 4'h0);
      for (int t = 0; t < 13; t++) begin
         step(1'b0, 4'hF, 4'hF);
         check(t % 3 == 0 ? "rr_grant" : "rr_gap", bus.req_ready, t % 3 == 0 ? 32'd1 << ((t / 3) % 4) : 32'd0);
      end
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      rand_ops();
      step(1'b0, 4'hF, 4'h0);
      check("bp_grant", bus.req_ready, 4'b0010);
      step(1'b0, 4'hF, 4'h0);
      step(1'b0, 4'hF, 4'b1101);
      hold = bus.rsp_result;
      for (int t = 0; t < 4; t++) begin
         step(1'b0, 4'hF, 4'b1101);
         check("bp_hold", bus.rsp_result, hold);
         check("bp_no_ready", bus.req_ready, 0);
      end
      step(1'b0, 4'hF, 4'b0010);
      step(1'b0, 4'hF, 4'h0);
      check("bp_idle", bus.busy, 0);
      check("bp_next_grant", bus.req_ready, 4'b0100);
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'h0, 4'hF);
      step(1'b0, 4'b1000, 4'h0);
      step(1'b1, 4'h0, 4'hF);
      for (int t = 0; t < 4; t++) begin
         step(1'b0, 4'h0, 4'hF);
         check("midrst_no_rsp", bus.rsp_valid, 0);
      end
      step(1'b0, 4'hF, 4'hF);
      check("midrst_ptr0", bus.req_ready, 4'b0001);
      for (int t = 0; t < 1500; t++) begin
         rand_ops();
         step($urandom_range(63) == 0, N'($urandom), N'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 32-bit ALU among NUM_REQ requesters (e.g. issue slots, address-gen, debug unit). Each requester has a valid/ready request channel carrying operands, 5-bit ALU control and shift amount, and a response channel carrying result/zero/overflow. Block registers the granted request onto the ALU input ports, captures ALU outputs next cycle, and holds the response until the owner accepts it. One operation in flight at a time.

Parameters:
WIDTH, 32, datapath width; SHW = $clog2(WIDTH)
NUM_REQ, 4, number of requesters (2..8); IDW = $clog2(NUM_REQ)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  request valid, bit i = requester i
req_ready  out  NUM_REQ  one-hot accept; asserted only in IDLE for granted requester
req_operand_a  in  NUM_REQ*WIDTH  packed, slice i = [i*WIDTH +: WIDTH]
req_operand_b  in  NUM_REQ*WIDTH  packed as above
req_alu_control  in  NUM_REQ*5  packed ALU control (bit4 logic/arith, [3:2] arith op, [0] signed)
req_shift_amount  in  NUM_REQ*SHW  packed shift amount
alu_operand_a  out  WIDTH  registered to ALU
alu_operand_b  out  WIDTH  registered to ALU
alu_control  out  5  registered to ALU
alu_shift_amount  out  SHW  registered to ALU
alu_result  in  WIDTH  from ALU
alu_zero  in  1  from ALU
alu_overflow  in  1  from ALU
rsp_valid  out  NUM_REQ  one-hot response valid to owner
rsp_ready  in  NUM_REQ  response accept, bit i from requester i
rsp_result  out  WIDTH  captured result
rsp_zero  out  1  captured zero flag
rsp_overflow  out  1  captured overflow flag
busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, rr_ptr=0, owner=0; all alu_* outputs, rsp_result/zero/overflow = 0; rsp_valid=0, busy=0. req_ready is 0 while rst is high. Reset mid-operation discards in-flight op; no response issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE: combinational grant = first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready = onehot(grant) when any req_valid, else 0. On handshake: latch granted slice into alu_* regs, owner<=grant, rr_ptr<=(grant+1) mod NUM_REQ, ->EXEC.
- EXEC (1 cycle): alu_* stable; at edge capture alu_result/zero/overflow into rsp_* regs, ->RESP.
- RESP: rsp_valid = onehot(owner); rsp_* held stable. On rsp_ready[owner]: ->IDLE. rsp_ready bits of non-owners ignored.
- Latency: request accepted cycle T -> rsp_valid high from T+2. Earliest next accept T+3 (rsp_ready at T+2). Throughput max 1 op / 3 cycles.
- alu_* regs hold last value in IDLE/RESP (no toggling on idle).
- req_ready never asserted outside IDLE; req_valid may drop without acceptance (no requirement to hold), but accepted data is the slice sampled at handshake.
- Fairness: requester continuously valid is granted within NUM_REQ arbitration rounds. rr_ptr only advances on a grant.
- No request with no req_valid: stays IDLE, nothing changes.
- busy = (state != IDLE).

Optional Feature:
ALU_ARB_PERF_EN: when defined, adds outputs perf_ops (32-bit) = count of completed responses (rsp handshake), and perf_wait (32-bit) = cycles where some req_valid bit is high but no req_ready is asserted; both reset to 0, saturate at 32'hFFFF_FFFF. When undefined, ports and counters absent; core behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy=0, alu_* = 0; after release requester 0 granted first.
- Single op: req_valid=0001, a=5, b=3, ctrl=5'b00000 (ADD), rsp_ready=1 -> alu_operand_a=5 at T+1, rsp_valid=0001 at T+2 with rsp_result=8, zero=0, overflow=0.
- Overflow/zero capture: requester 2 signed ADD 0x7FFF_FFFF+1 -> rsp_overflow=1, rsp_valid=0100; then SUB 7-7 -> rsp_result=0, rsp_zero=1.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0 on accepts at T, T+3, T+6, T+9, T+12.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0 throughout, other req_valid pending; rsp_ready[owner]=1 -> IDLE next cycle, new grant following cycle; rsp_ready on non-owner ignored.
- Reset mid-op: assert rst in EXEC -> next cycle IDLE, no rsp_valid ever issued for that op, rr_ptr=0.
